// File: rtl/bmp_scan_ctrl.sv
// Bitmap scan controller: finds the first set row from the top and from the
// bottom of a bitmap, then walks its columns, handing each slice to the ALU.
module bmp_scan_ctrl #(
  parameter int NUM_ROWS = 64,
  parameter int NUM_COLS = 24,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rowtopready,
  input  logic       rowbotready,
  input  logic       colready,
  input  logic       finalcolumn,
  input  logic       alu_done,
  input  logic       alu_hit,
  output logic       nextrowtop,
  output logic       nextrowbot,
  output logic       nextcol,
  output logic       alu_go,
  output logic [1:0] alu_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] top_idx,
  output logic [5:0] bot_idx,
  output logic [4:0] col_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ALU, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    PH_TOP = 2'b00,
    PH_BOT = 2'b01,
    PH_COL = 2'b10
  } phase_t;

  localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [5:0] ROW_LAST = 6'(NUM_ROWS - 1);
  localparam logic [4:0] COL_MAX  = 5'(NUM_COLS);

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [5:0]    top_n, bot_n;
  logic [4:0]    col_n;
  logic          err_n;
  logic [TW-1:0] timer, timer_n;
  logic          final_seen, final_n;
  logic          phase_ready;
  logic [5:0]    bot_limit;

  // The bottom scan may never run past the row where the top scan found its hit
  assign bot_limit = ROW_LAST - top_idx;

  // Select the ready flag that belongs to the slice type being scanned
  always_comb begin
    phase_ready = 1'b0;
    case (phase)
      PH_TOP:  phase_ready = rowtopready;
      PH_BOT:  phase_ready = rowbotready;
      default: phase_ready = colready;
    endcase
  end

  // Next-state, counter updates and Moore/Mealy outputs of the scan sequencer
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    top_n      = top_idx;
    bot_n      = bot_idx;
    col_n      = col_cnt;
    err_n      = err;
    timer_n    = timer;
    final_n    = final_seen;
    nextrowtop = 1'b0;
    nextrowbot = 1'b0;
    nextcol    = 1'b0;
    alu_go     = 1'b0;
    alu_sel    = 2'b00;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          top_n   = '0;
          bot_n   = '0;
          col_n   = '0;
          err_n   = 1'b0;
          final_n = 1'b0;
          phase_n = PH_TOP;
          state_n = S_REQ;
        end
      end

      S_REQ: begin
        nextrowtop = (phase == PH_TOP);
        nextrowbot = (phase == PH_BOT);
        nextcol    = (phase == PH_COL);
        timer_n    = '0;
        state_n    = S_WAIT;
      end

      S_WAIT: begin
        alu_sel = phase;
        if (phase_ready) begin
          alu_go  = 1'b1;
          final_n = finalcolumn;
          state_n = S_ALU;
        end else if (int'(timer) + 2 >= TIMEOUT) begin
          // The request cycle counts toward the budget, so err rises exactly
          // TIMEOUT cycles after the request pulse.
          err_n   = 1'b1;
          state_n = S_ERR;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      S_ALU: begin
        alu_sel = phase;
        if (alu_done) begin
          state_n = S_REQ;
          case (phase)
            PH_TOP: begin
              if (alu_hit) begin
                phase_n = PH_BOT;
              end else if (top_idx >= ROW_LAST) begin
                top_n   = ROW_LAST;
                bot_n   = ROW_LAST;
                state_n = S_DONE;
              end else begin
                top_n = top_idx + 6'd1;
              end
            end
            PH_BOT: begin
              if (alu_hit || (bot_idx >= bot_limit)) begin
                phase_n = PH_COL;
              end else begin
                bot_n = bot_idx + 6'd1;
                if (bot_idx + 6'd1 == bot_limit) phase_n = PH_COL;
              end
            end
            default: begin
              if (col_cnt < COL_MAX) col_n = col_cnt + 5'd1;
              if (final_seen || (col_cnt >= COL_MAX - 5'd1)) state_n = S_DONE;
            end
          endcase
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      S_ERR: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any scan in progress at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= PH_TOP;
      top_idx    <= '0;
      bot_idx    <= '0;
      col_cnt    <= '0;
      err        <= 1'b0;
      timer      <= '0;
      final_seen <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      top_idx    <= top_n;
      bot_idx    <= bot_n;
      col_cnt    <= col_n;
      err        <= err_n;
      timer      <= timer_n;
      final_seen <= final_n;
    end
  end

endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// Testbench for bmp_scan_ctrl: the bench plays bitmap register and ALU for a
// random bitmap and compares the scan results against a row/column model.
module tb_bmp_scan_ctrl;

  localparam int NUM_ROWS = 64;
  localparam int NUM_COLS = 24;
  localparam int TIMEOUT  = 15;
  localparam int BUDGET   = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, rowtopready, rowbotready, colready, finalcolumn;
  logic       alu_done, alu_hit;
  logic       nextrowtop, nextrowbot, nextcol, alu_go;
  logic [1:0] alu_sel;
  logic       busy, done, err;
  logic [5:0] top_idx, bot_idx;
  logic [4:0] col_cnt;

  int checks = 0;
  int errors = 0;

  bit rows [NUM_ROWS];
  int fcol;

  int n_top, n_bot, n_col, n_go, n_done, n_proto, cyc_col, cyc_err;
  bit saw_err, busy_at_err, timed_out;

  bmp_scan_ctrl #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rowtopready(rowtopready), .rowbotready(rowbotready),
    .colready(colready), .finalcolumn(finalcolumn),
    .alu_done(alu_done), .alu_hit(alu_hit),
    .nextrowtop(nextrowtop), .nextrowbot(nextrowbot), .nextcol(nextcol),
    .alu_go(alu_go), .alu_sel(alu_sel),
    .busy(busy), .done(done), .err(err),
    .top_idx(top_idx), .bot_idx(bot_idx), .col_cnt(col_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic drive_idle();
    start       = 1'b0;
    rowtopready = 1'b0;
    rowbotready = 1'b0;
    colready    = 1'b0;
    finalcolumn = 1'b0;
    alu_done    = 1'b0;
    alu_hit     = 1'b0;
  endtask

  // Reference: first set row from the top, first set row from the bottom,
  // clipped to the top hit, then columns up to the flagged last one.
  function automatic void model(output int e_top, output int e_bot, output int e_col,
                                output int e_ntop, output int e_nbot, output int e_ncol);
    int t = -1;
    int b = -1;
    int limit;
    for (int i = 0; i < NUM_ROWS; i++) if (t < 0 && rows[i]) t = i;
    if (t < 0) begin
      e_top = NUM_ROWS - 1; e_bot = NUM_ROWS - 1; e_col = 0;
      e_ntop = NUM_ROWS; e_nbot = 0; e_ncol = 0;
      return;
    end
    for (int j = 0; j < NUM_ROWS; j++) if (b < 0 && rows[NUM_ROWS-1-j]) b = j;
    limit  = NUM_ROWS - 1 - t;
    e_top  = t;
    e_bot  = b;
    e_ntop = t + 1;
    e_nbot = (b < limit) ? b + 1 : ((limit > 0) ? limit : 1);
    e_ncol = (fcol + 1 < NUM_COLS) ? fcol + 1 : NUM_COLS;
    e_col  = e_ncol;
  endfunction

  task automatic make_bitmap(input bit allow_empty);
    int t;
    for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
    if (!allow_empty || $urandom_range(0, 5) != 0) begin
      t = $urandom_range(0, NUM_ROWS - 1);
      rows[t] = 1'b1;
      for (int k = 0; k < 3; k++) rows[$urandom_range(t, NUM_ROWS - 1)] = 1'b1;
    end
    fcol = $urandom_range(0, NUM_COLS + 2);
  endtask

  // Issues a start, then answers every request like the bitmap register and ALU
  task automatic applyStimulus(input bit noise, input bit hold_col, input bit stop_at_bot);
    int cyc = 0, kind = -1, rdy_wait = -1, dn_wait = -1;
    int tcount = 0, bcount = 0, ccount = 0;
    bit rdy_on = 0, in_wait = 0, pend_hit = 0, pend_final = 0, finished = 0;
    bit prev_t = 0, prev_b = 0, prev_c = 0;
    bit nd, ns_done, ns_col, ns_start;
    n_top = 0; n_bot = 0; n_col = 0; n_go = 0; n_done = 0; n_proto = 0;
    cyc_col = -1; cyc_err = -1; saw_err = 0; busy_at_err = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (int'(nextrowtop) + int'(nextrowbot) + int'(nextcol) > 1) n_proto++;
      if ((nextrowtop && prev_t) || (nextrowbot && prev_b) || (nextcol && prev_c)) n_proto++;
      prev_t = nextrowtop; prev_b = nextrowbot; prev_c = nextcol;
      if (nextrowtop) begin
        n_top++; kind = 0; in_wait = 1;
        pend_hit = (tcount < NUM_ROWS) ? rows[tcount] : 1'b0;
        tcount++;
        rdy_wait = $urandom_range(0, 2);
      end
      if (nextrowbot) begin
        n_bot++; kind = 1; in_wait = 1;
        pend_hit = (bcount < NUM_ROWS) ? rows[NUM_ROWS-1-bcount] : 1'b0;
        bcount++;
        rdy_wait = $urandom_range(0, 2);
        if (stop_at_bot) finished = 1;
      end
      if (nextcol) begin
        n_col++; kind = 2; in_wait = 1; cyc_col = cyc;
        pend_final = (ccount == fcol);
        ccount++;
        rdy_wait = hold_col ? -1 : int'($urandom_range(0, 2));
      end
      if (alu_go) begin
        n_go++;
        if (int'(alu_sel) != kind) n_proto++;
        rdy_on = 0; in_wait = 0;
        dn_wait = $urandom_range(0, 2);
      end
      if (done) begin n_done++; finished = 1; end
      if (err) begin saw_err = 1; cyc_err = cyc; busy_at_err = busy; finished = 1; end
      if (rdy_wait == 0) begin rdy_on = 1; rdy_wait = -1; end
      else if (rdy_wait > 0) rdy_wait--;
      nd = 0;
      if (dn_wait == 0) begin nd = 1; dn_wait = -1; end
      else if (dn_wait > 0) dn_wait--;
      ns_done  = noise && in_wait && !rdy_on && ($urandom_range(0, 2) == 0);
      ns_col   = noise && in_wait && kind == 0 && ($urandom_range(0, 2) == 0);
      ns_start = noise && in_wait && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      rowtopready = rdy_on && kind == 0;
      rowbotready = rdy_on && kind == 1;
      colready    = (rdy_on && kind == 2) || ns_col;
      finalcolumn = rdy_on && kind == 2 && pend_final;
      alu_done    = nd || ns_done;
      alu_hit     = nd ? pend_hit : 1'($urandom_range(0, 1));
      start       = ns_start;
    end
    drive_idle();
    timed_out = !finished;
  endtask

  task automatic test_reset();
    logic [25:0] outv;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    outv = {nextrowtop, nextrowbot, nextcol, alu_go, alu_sel, busy, done, err, top_idx, bot_idx, col_cnt};
    checks++;
    if (outv !== 26'd0) begin errors++; $display("[TB] FAIL reset_outputs got %h want 0", outv); end
    @(posedge clk); #1 start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || nextrowtop !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wait_start busy=%b nextrowtop=%b want 0 0", busy, nextrowtop);
    end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
    rows[2] = 1'b1;
    rows[NUM_ROWS-2] = 1'b1;
    fcol = NUM_COLS - 1;
    applyStimulus(0, 0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL nominal_finish got no done want done"); end
    checks++; if (top_idx !== 6'd2) begin errors++; $display("[TB] FAIL nominal_top got %0d want 2", top_idx); end
    checks++; if (bot_idx !== 6'd1) begin errors++; $display("[TB] FAIL nominal_bot got %0d want 1", bot_idx); end
    checks++; if (col_cnt !== 5'd24) begin errors++; $display("[TB] FAIL nominal_col got %0d want 24", col_cnt); end
    checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL nominal_done got %0d want 1", n_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL nominal_err got %b want 0", err); end
    checks++; if (n_proto != 0) begin errors++; $display("[TB] FAIL nominal_proto got %0d want 0", n_proto); end
  endtask

  task automatic test_empty();
    for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
    fcol = NUM_COLS - 1;
    applyStimulus(0, 0, 0);
    checks++; if (n_top != 64) begin errors++; $display("[TB] FAIL empty_ntop got %0d want 64", n_top); end
    checks++; if (n_bot + n_col != 0) begin errors++; $display("[TB] FAIL empty_nbotcol got %0d want 0", n_bot + n_col); end
    checks++; if (top_idx !== 6'd63) begin errors++; $display("[TB] FAIL empty_top got %0d want 63", top_idx); end
    checks++; if (bot_idx !== 6'd63) begin errors++; $display("[TB] FAIL empty_bot got %0d want 63", bot_idx); end
    checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL empty_done got %0d want 1", n_done); end
  endtask

  task automatic test_random(input int iters, input bit noise);
    int e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol;
    for (int it = 0; it < iters; it++) begin
      if (it == 0) begin
        for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
        rows[NUM_ROWS-1] = 1'b1;
        fcol = $urandom_range(0, NUM_COLS + 2);
      end else begin
        make_bitmap(1);
      end
      model(e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol);
      applyStimulus(noise, 0, 0);
      checks++; if (timed_out) begin errors++; $display("[TB] FAIL rand%0d_finish got no done want done", it); end
      checks++; if (int'(top_idx) != e_top) begin errors++; $display("[TB] FAIL rand%0d_top got %0d want %0d", it, top_idx, e_top); end
      checks++; if (int'(bot_idx) != e_bot) begin errors++; $display("[TB] FAIL rand%0d_bot got %0d want %0d", it, bot_idx, e_bot); end
      checks++; if (int'(col_cnt) != e_col) begin errors++; $display("[TB] FAIL rand%0d_col got %0d want %0d", it, col_cnt, e_col); end
      checks++; if (n_top != e_ntop || n_bot != e_nbot || n_col != e_ncol) begin
        errors++; $display("[TB] FAIL rand%0d_pulses got %0d/%0d/%0d want %0d/%0d/%0d", it, n_top, n_bot, n_col, e_ntop, e_nbot, e_ncol);
      end
      checks++; if (n_go != e_ntop + e_nbot + e_ncol) begin errors++; $display("[TB] FAIL rand%0d_alu_go got %0d want %0d", it, n_go, e_ntop + e_nbot + e_ncol); end
      checks++; if (n_done != 1 || err !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL rand%0d_status got done=%0d err=%b busy=%b want 1 0 0", it, n_done, err, busy);
      end
      checks++; if (n_proto != 0) begin errors++; $display("[TB] FAIL rand%0d_proto got %0d want 0", it, n_proto); end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
    rows[3] = 1'b1;
    rows[NUM_ROWS-1] = 1'b1;
    fcol = NUM_COLS - 1;
    applyStimulus(0, 1, 0);
    checks++; if (!saw_err) begin errors++; $display("[TB] FAIL timeout_err got 0 want 1"); end
    checks++; if (cyc_err - cyc_col != TIMEOUT) begin
      errors++; $display("[TB] FAIL timeout_delay got %0d want %0d", cyc_err - cyc_col, TIMEOUT);
    end
    checks++; if (busy_at_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got %b want 0", busy_at_err); end
    checks++; if (n_done != 0) begin errors++; $display("[TB] FAIL timeout_done got %0d want 0", n_done); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_sticky got err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  task automatic checkOutput_reset_mid();
    logic [25:0] outv;
    int stray = 0;
    int e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol;
    for (int i = 0; i < NUM_ROWS; i++) rows[i] = 1'b0;
    rows[5] = 1'b1;
    rows[NUM_ROWS-4] = 1'b1;
    fcol = NUM_COLS - 1;
    applyStimulus(0, 0, 1);
    checks++; if (n_bot != 1) begin errors++; $display("[TB] FAIL rstmid_reach_bot got %0d want 1", n_bot); end
    rst = 1'b1;
    #1;
    outv = {nextrowtop, nextrowbot, nextcol, alu_go, alu_sel, busy, done, err, top_idx, bot_idx, col_cnt};
    checks++; if (outv !== 26'd0) begin errors++; $display("[TB] FAIL rstmid_outputs got %h want 0", outv); end
    repeat (2) begin
      @(negedge clk);
      if (nextrowtop || nextrowbot || nextcol || busy) stray++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (nextrowtop || nextrowbot || nextcol || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL rstmid_quiet got %0d want 0", stray); end
    make_bitmap(0);
    model(e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol);
    applyStimulus(0, 0, 0);
    checks++; if (int'(top_idx) != e_top || int'(bot_idx) != e_bot || int'(col_cnt) != e_col) begin
      errors++; $display("[TB] FAIL rstmid_rescan got %0d/%0d/%0d want %0d/%0d/%0d", top_idx, bot_idx, col_cnt, e_top, e_bot, e_col);
    end
    checks++; if (n_done != 1 || err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rescan_done got %0d err=%b want 1 0", n_done, err); end
  endtask

  task automatic test_back_to_back();
    int e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol;
    for (int it = 0; it < 2; it++) begin
      make_bitmap(0);
      model(e_top, e_bot, e_col, e_ntop, e_nbot, e_ncol);
      applyStimulus(1, 0, 0);
      checks++; if (int'(top_idx) != e_top || int'(bot_idx) != e_bot || int'(col_cnt) != e_col) begin
        errors++; $display("[TB] FAIL b2b%0d_result got %0d/%0d/%0d want %0d/%0d/%0d", it, top_idx, bot_idx, col_cnt, e_top, e_bot, e_col);
      end
      checks++; if (n_done != 1 || n_proto != 0) begin
        errors++; $display("[TB] FAIL b2b%0d_protocol got done=%0d proto=%0d want 1 0", it, n_done, n_proto);
      end
    end
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_nominal();
    test_empty();
    test_random(10, 0);
    test_random(6, 1);
    test_timeout();
    checkOutput_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
